// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage link carrying a payload word and a control vector.
// master drives valid/data/ctrl and samples ready; slave does the reverse.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional 2-entry skid buffer and flush; 1-cycle latency, full throughput.
// Backpressure: SKID=1 absorbs one extra item behind a registered in_ready; SKID=0 gates in_ready on out_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5,
   parameter int SKID   = 1
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stage_reg_if.slave  in_if,
   pipe_stage_reg_if.master out_if,
   input  logic             flush,
   output logic [1:0]       occupancy
);

   logic              main_vld_q, main_vld_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              skid_vld_q, skid_vld_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic              in_ready_q, in_ready_d;
   logic              accept, consume;

   assign accept  = in_if.valid & in_if.ready;
   assign consume = main_vld_q & out_if.ready;

   always_comb begin
      main_vld_d  = main_vld_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
         // Payload registers keep their contents; only the valid bits drop.
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (consume && skid_vld_q) begin
         main_data_d = skid_data_q;
         main_ctrl_d = skid_ctrl_q;
         skid_vld_d  = 1'b0;
      end else if (accept && (consume || !main_vld_q)) begin
         main_vld_d  = 1'b1;
         main_data_d = in_if.data;
         main_ctrl_d = in_if.ctrl;
      end else if (accept) begin
         // Only reachable with the skid buffer: main is stalled, park the item.
         skid_vld_d  = 1'b1;
         skid_data_d = in_if.data;
         skid_ctrl_d = in_if.ctrl;
      end else if (consume) begin
         main_vld_d = 1'b0;
      end
      in_ready_d = !(main_vld_d && skid_vld_d);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         main_vld_q  <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b0;
      end else begin
         main_vld_q  <= main_vld_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_if.ready  = (SKID != 0) ? in_ready_q : (!main_vld_q || out_if.ready);
   assign out_if.valid = main_vld_q;
   assign out_if.data  = main_data_q;
   assign out_if.ctrl  = main_vld_q ? main_ctrl_q : '0;
   assign occupancy    = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table on the skid build, hand sequence on the
// single-register build, then random traffic on both against a queue model.
module tb_pipe_stage_reg;

   logic       clk;
   logic       rst;
   logic       flush1, flush0;
   logic [1:0] occ1, occ0;

   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) in1_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) out1_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) in0_if ();
   pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(5)) out0_if ();

   pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_if(in1_if), .out_if(out1_if), .flush(flush1), .occupancy(occ1)
   );
   pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .SKID(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_if(in0_if), .out_if(out0_if), .flush(flush0), .occupancy(occ0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        iv;
      logic [31:0] d;
      logic [4:0]  c;
      logic        ordy;
      logic        fl;
      logic        ov;
      logic [31:0] od;
      logic [4:0]  oc;
      logic [1:0]  occ;
      logic        ir;
   } vec_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  c;
   } item_t;

   vec_t  vq[$];
   item_t q1[$];
   item_t q0[$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic [4:0] c,
                      input logic ordy, input logic fl, input logic ov, input logic [31:0] od,
                      input logic [4:0] oc, input logic [1:0] occ, input logic ir);
      vec_t v;
      v.r = r; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
      v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.ir = ir;
      vq.push_back(v);
   endtask

   initial begin
      logic  ir1_m, exp_ir0, acc1, acc0, cons1, cons0, acc1_last, acc0_last;
      item_t it;

      rst = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
      in1_if.valid = 1'b0; in1_if.data = '0; in1_if.ctrl = '0; out1_if.ready = 1'b0;
      in0_if.valid = 1'b0; in0_if.data = '0; in0_if.ctrl = '0; out0_if.ready = 1'b1;

      //   r iv data     ctrl  ordy fl | ov data   ctrl  occ ir
      add(0, 1, 'hDEAD, 0,     0, 0,    0, 0,     0,     0, 0);
      add(0, 1, 'hDEAD, 0,     0, 0,    0, 0,     0,     0, 0);
      add(1, 0, 0,      0,     1, 0,    0, 0,     0,     0, 1);
      add(1, 1, 1,      'h15,  1, 0,    1, 1,     'h15,  1, 1);
      add(1, 1, 2,      'h15,  1, 0,    1, 2,     'h15,  1, 1);
      add(1, 1, 3,      'h15,  1, 0,    1, 3,     'h15,  1, 1);
      add(1, 0, 0,      0,     1, 0,    0, 3,     0,     0, 1);
      add(1, 1, 'hA,    3,     0, 0,    1, 'hA,   3,     1, 1);
      add(1, 1, 'hB,    'hC,   0, 0,    1, 'hA,   3,     2, 0);
      add(1, 0, 0,      0,     0, 0,    1, 'hA,   3,     2, 0);
      add(1, 0, 0,      0,     1, 0,    1, 'hB,   'hC,   1, 1);
      add(1, 0, 0,      0,     1, 0,    0, 'hB,   0,     0, 1);
      add(1, 1, 'hA,    3,     0, 0,    1, 'hA,   3,     1, 1);
      add(1, 1, 'hB,    'hC,   0, 0,    1, 'hA,   3,     2, 0);
      add(1, 1, 'hC,    7,     0, 1,    0, 'hA,   0,     0, 1);
      add(1, 0, 0,      0,     1, 0,    0, 'hA,   0,     0, 1);
      add(1, 1, 'h11,   1,     0, 0,    1, 'h11,  1,     1, 1);
      add(1, 1, 'h22,   2,     1, 1,    0, 'h11,  0,     0, 1);
      add(1, 0, 0,      0,     1, 0,    0, 'h11,  0,     0, 1);
      add(1, 1, 'h30,   1,     0, 0,    1, 'h30,  1,     1, 1);
      add(1, 1, 'h31,   2,     0, 0,    1, 'h30,  1,     2, 0);
      add(0, 0, 0,      0,     0, 0,    0, 0,     0,     0, 0);
      add(1, 0, 0,      0,     1, 0,    0, 0,     0,     0, 1);
      add(1, 1, 7,      'h1F,  1, 0,    1, 7,     'h1F,  1, 1);
      add(1, 0, 0,      0,     1, 0,    0, 7,     0,     0, 1);
      add(0, 1, 5,      1,     1, 1,    0, 0,     0,     0, 0);
      add(1, 0, 0,      0,     1, 0,    0, 0,     0,     0, 1);

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         rst = vq[i].r; in1_if.valid = vq[i].iv; in1_if.data = vq[i].d;
         in1_if.ctrl = vq[i].c; out1_if.ready = vq[i].ordy; flush1 = vq[i].fl;
         @(posedge clk); #1;
         chk($sformatf("v%0d.out_valid", i), {31'd0, out1_if.valid}, {31'd0, vq[i].ov});
         chk($sformatf("v%0d.out_data", i), out1_if.data, vq[i].od);
         chk($sformatf("v%0d.out_ctrl", i), {27'd0, out1_if.ctrl}, {27'd0, vq[i].oc});
         chk($sformatf("v%0d.occupancy", i), {30'd0, occ1}, {30'd0, vq[i].occ});
         chk($sformatf("v%0d.in_ready", i), {31'd0, in1_if.ready}, {31'd0, vq[i].ir});
      end

      // Single-register build: in_ready follows out_ready combinationally.
      @(negedge clk);
      in1_if.valid = 1'b0; flush1 = 1'b0;
      in0_if.valid = 1'b1; in0_if.data = 32'h8; in0_if.ctrl = 5'h2; out0_if.ready = 1'b0;
      @(posedge clk); #1;
      chk("s0.out_valid_8", {31'd0, out0_if.valid}, 32'd1);
      chk("s0.out_data_8", out0_if.data, 32'h8);
      chk("s0.occ_8", {30'd0, occ0}, 32'd1);
      chk("s0.in_ready_blocked", {31'd0, in0_if.ready}, 32'd0);
      in0_if.data = 32'h9; in0_if.ctrl = 5'h3; out0_if.ready = 1'b1;
      #1;
      chk("s0.in_ready_comb", {31'd0, in0_if.ready}, 32'd1);
      @(posedge clk); #1;
      chk("s0.out_data_9", out0_if.data, 32'h9);
      chk("s0.out_ctrl_9", {27'd0, out0_if.ctrl}, 32'h3);
      chk("s0.occ_9", {30'd0, occ0}, 32'd1);
      in0_if.valid = 1'b0;
      @(posedge clk); #1;
      chk("s0.bubble_valid", {31'd0, out0_if.valid}, 32'd0);
      chk("s0.bubble_ctrl", {27'd0, out0_if.ctrl}, 32'd0);
      chk("s0.bubble_data_held", out0_if.data, 32'h9);

      // Random traffic on both builds against an item-queue model.
      @(negedge clk);
      rst = 1'b0; in0_if.valid = 1'b0; in1_if.valid = 1'b0;
      @(posedge clk);
      q1.delete(); q0.delete();
      ir1_m = 1'b0; acc1_last = 1'b1; acc0_last = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) != 0);
         if (!in1_if.valid || acc1_last) begin
            in1_if.valid = ($urandom_range(0, 9) < 7);
            in1_if.data  = $urandom;
            in1_if.ctrl  = 5'($urandom);
         end
         if (!in0_if.valid || acc0_last) begin
            in0_if.valid = ($urandom_range(0, 9) < 7);
            in0_if.data  = $urandom;
            in0_if.ctrl  = 5'($urandom);
         end
         out1_if.ready = ($urandom_range(0, 9) < 6);
         out0_if.ready = ($urandom_range(0, 9) < 6);
         flush1 = ($urandom_range(0, 15) == 0);
         flush0 = ($urandom_range(0, 15) == 0);
         #1;
         exp_ir0 = (q0.size() == 0) || out0_if.ready;
         chk("r0.in_ready", {31'd0, in0_if.ready}, {31'd0, exp_ir0});
         acc1  = in1_if.valid && ir1_m;
         acc0  = in0_if.valid && exp_ir0;
         cons1 = (q1.size() > 0) && out1_if.ready;
         cons0 = (q0.size() > 0) && out0_if.ready;
         @(posedge clk); #1;
         if (!rst) begin
            q1.delete(); q0.delete();
            ir1_m = 1'b0;
         end else begin
            if (flush1) q1.delete();
            else begin
               if (cons1) void'(q1.pop_front());
               if (acc1) begin it.d = in1_if.data; it.c = in1_if.ctrl; q1.push_back(it); end
            end
            if (flush0) q0.delete();
            else begin
               if (cons0) void'(q0.pop_front());
               if (acc0) begin it.d = in0_if.data; it.c = in0_if.ctrl; q0.push_back(it); end
            end
            ir1_m = (q1.size() < 2);
         end
         acc1_last = acc1;
         acc0_last = acc0;
         chk("r1.out_valid", {31'd0, out1_if.valid}, {31'd0, (q1.size() > 0)});
         chk("r1.occupancy", {30'd0, occ1}, q1.size());
         chk("r1.in_ready", {31'd0, in1_if.ready}, {31'd0, ir1_m});
         if (q1.size() > 0) begin
            chk("r1.out_data", out1_if.data, q1[0].d);
            chk("r1.out_ctrl", {27'd0, out1_if.ctrl}, {27'd0, q1[0].c});
         end else begin
            chk("r1.bubble_ctrl", {27'd0, out1_if.ctrl}, 32'd0);
         end
         chk("r0.out_valid", {31'd0, out0_if.valid}, {31'd0, (q0.size() > 0)});
         chk("r0.occupancy", {30'd0, occ0}, q0.size());
         if (q0.size() > 0) begin
            chk("r0.out_data", out0_if.data, q0[0].d);
            chk("r0.out_ctrl", {27'd0, out0_if.ctrl}, {27'd0, q0[0].c});
         end else begin
            chk("r0.bubble_ctrl", {27'd0, out0_if.ctrl}, 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register and successor to the fixed-field EX/MEM latch. Carries a generic payload plus a control vector between stages, adds valid/ready handshaking, a 2-entry skid buffer for full throughput under backpressure, and synchronous flush (bubble insertion). It is instantiated between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
DATA_W, 32, payload width (PC, ALU result, store data, dest reg packed by instantiator); held on bubble
CTRL_W, 5, control-bit width (Branch, MemW, RegW, Mem2R…); forced to 0 on bubble/flush
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  upstream item valid
in_ready  out  1  stage can accept
in_data  in  DATA_W  upstream payload
in_ctrl  in  CTRL_W  upstream control bits
flush  in  1  discard all held items (branch taken / exception)
out_valid  out  1  output item valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  payload to next stage
out_ctrl  out  CTRL_W  control to next stage; 0 when out_valid=0
occupancy  out  2  items held, 0..2 (0..1 when SKID=0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low: rst==0 sampled at posedge clk takes effect.
- Reset: out_valid=0, out_data=0, out_ctrl=0, skid empty, occupancy=0. SKID=1: in_ready=0 while rst low, 1 from the first posedge with rst high. Reset mid-operation discards both entries.
- Handshakes: accept = in_valid & in_ready at posedge; consume = out_valid & out_ready at posedge.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data/out_ctrl are stable.
  - Upstream must not drop in_valid or change in_data before acceptance; not checked.
- Latency: accepted item appears on out_* the next cycle when the main register is free. Throughput is 1 item/cycle with out_ready held high.
- SKID=1, two registers, main (drives out_*) and skid. States EMPTY(0), ONE(1), FULL(2):
  - EMPTY: accept -> main, ONE.
  - ONE, accept & consume: new item -> main, stay ONE.
  - ONE, accept & no consume: item -> skid, FULL; in_ready=0 next cycle.
  - ONE, consume only: EMPTY.
  - FULL, consume: skid -> main, ONE; in_ready=1 next cycle. No accept is possible in FULL.
  - FULL, no consume: hold.
  - in_ready is a register, in_ready = (next state != FULL). It never depends combinationally on out_ready.
- SKID=0: single register. in_ready = ~out_valid | out_ready (combinational); occupancy is 0 or 1.
- Ordering is strictly FIFO; no item is duplicated or lost except by flush or reset.
- Bubble: when out_valid=0, out_ctrl=0 and out_data holds its last value.
- Flush (priority below reset, above all else):
  - At the posedge: both entries invalidated, out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 next cycle.
  - An item accepted in the flush cycle is dropped; the upstream handshake still completes.
  - An item consumed in the flush cycle counts as delivered.
- Simultaneous flush and rst low: reset wins, so in_ready=0 during reset.
- Ctrl/data widths are passed through unchanged; there is no arithmetic.

Test Plan:
1. Reset: rst=0 for 2 cycles with in_valid=1, in_data=0xDEAD -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=0; first cycle after rst=1 -> in_ready=1.
2. Streaming: out_ready=1, feed 0x1,0x2,0x3 on consecutive cycles with ctrl=5'b10101 -> out_data 0x1,0x2,0x3 one cycle later each, occupancy=1, in_ready stays 1.
3. Backpressure: out_ready=0, feed 0xA then 0xB -> occupancy=2, in_ready=0, out_data=0xA stable. Raise out_ready -> 0xA, 0xB in order, in_ready=1 the cycle after 0xA leaves.
4. Flush when FULL: hold 0xA/0xB, assert flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; 0xC never appears.
5. Reset mid-operation: occupancy=2, rst=0 one cycle -> outputs at reset values. Post-reset stream 0x7 emerges alone.
6. SKID=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. Toggle out_ready=1 -> in_ready=1 combinationally, and 0x9 accepted and visible next cycle.
